mux_4_1_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the shared 4:1 data mux. Four requesters (a, b, c, d) each present a request and a WIDTH-bit word. The block grants one requester at a time, drives the mux select, and forwards the selected word to a single downstream consumer through a valid/ready handshake. Grants are bounded to MAX_BURST accepted beats so that no requester starves the others.

---
 rtl/mux_4_1_rr_arbiter.sv | 123 ++++++++++++
 tb/tb_mux_4_1_rr_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mux_4_1_rr_arbiter.sv
// Round-robin arbiter that sequences four requesters onto one shared 4:1 data mux.
// Each grant is released when its requester withdraws or after MAX_BURST accepted beats.
module mux_4_1_rr_arbiter #(
  parameter int WIDTH     = 4,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic             out_ready,
  output logic [3:0]       grant,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

  state_t     state;
  state_t     state_nxt;
  logic [1:0] last;
  logic [1:0] last_nxt;
  logic [1:0] sel_nxt;
  logic [3:0] grant_nxt;
  logic [3:0] beats;
  logic [3:0] beats_nxt;
  logic [1:0] winner;
  logic [1:0] cand;
  logic       found;
  logic       xfer;
  logic       release_grant;

  // Scan last+1 .. last+4 so the previous winner always ranks lowest.
  always_comb begin
    winner = last;
    cand   = last;
    found  = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cand = last + 2'(i);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign out_valid     = (state == BUSY) && req[sel];
  assign xfer          = out_valid && out_ready;
  assign release_grant = (state == BUSY) &&
                         (!req[sel] || (xfer && (beats == LAST_BEAT)));

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    sel_nxt   = sel;
    last_nxt  = last;
    beats_nxt = beats;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = BUSY;
          grant_nxt = 4'b0001 << winner;
          sel_nxt   = winner;
          last_nxt  = winner;
          beats_nxt = 4'd0;
        end
      end
      BUSY: begin
        if (release_grant) begin
          state_nxt = IDLE;
          grant_nxt = 4'd0;
          beats_nxt = 4'd0;
        end else if (xfer) begin
          beats_nxt = beats + 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = 4'd0;
        beats_nxt = 4'd0;
      end
    endcase
  end

  // last resets to 3 so requester a wins the first arbitration.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      grant <= 4'd0;
      sel   <= 2'd0;
      last  <= 2'd3;
      beats <= 4'd0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      sel   <= sel_nxt;
      last  <= last_nxt;
      beats <= beats_nxt;
    end
  end

  always_comb begin
    out = '0;
    if (out_valid) begin
      case (sel)
        2'd0: out = a;
        2'd1: out = b;
        2'd2: out = c;
        2'd3: out = d;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_4_1_rr_arbiter.sv
// Directed bench for mux_4_1_rr_arbiter: a per-cycle vector table plus hand-written
// backpressure and asynchronous-reset sequences.
module tb_mux_4_1_rr_arbiter;

  localparam logic [3:0] A_VAL = 4'h1;
  localparam logic [3:0] B_VAL = 4'h2;
  localparam logic [3:0] C_VAL = 4'hA;
  localparam logic [3:0] D_VAL = 4'h8;

  logic       clk;
  logic       rstn;
  logic [3:0] req;
  logic [3:0] a, b, c, d;
  logic       out_ready;
  logic [3:0] grant;
  logic [1:0] sel;
  logic [3:0] out;
  logic       out_valid;

  int vectorsApplied = 0;
  int miscompares    = 0;

  typedef struct {
    string      name;
    logic       rstn;
    logic [3:0] req;
    logic       rdy;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       selCare;
    logic [3:0] out;
    logic       valid;
  } vec_t;

  vec_t vecTable[$];

  mux_4_1_rr_arbiter #(.WIDTH(4), .MAX_BURST(4)) dut (
    .clk(clk),
    .rstn(rstn),
    .req(req),
    .a(a),
    .b(b),
    .c(c),
    .d(d),
    .out_ready(out_ready),
    .grant(grant),
    .sel(sel),
    .out(out),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] dataOf(input int idx);
    case (idx)
      0:       return A_VAL;
      1:       return B_VAL;
      2:       return C_VAL;
      default: return D_VAL;
    endcase
  endfunction

  task automatic addVec(input string nm, input logic r, input logic [3:0] q, input logic rdy,
                        input logic [3:0] g, input logic [1:0] s, input logic care,
                        input logic [3:0] o, input logic v);
    vec_t e;
    e.name = nm; e.rstn = r; e.req = q; e.rdy = rdy;
    e.grant = g; e.sel = s; e.selCare = care; e.out = o; e.valid = v;
    vecTable.push_back(e);
  endtask

  task automatic addIdle(input string nm, input logic [3:0] q, input logic care);
    addVec(nm, 1'b1, q, 1'b1, 4'd0, 2'd0, care, 4'd0, 1'b0);
  endtask

  task automatic addBusy(input string nm, input logic [3:0] q, input int idx);
    addVec(nm, 1'b1, q, 1'b1, 4'b0001 << idx, 2'(idx), 1'b1, dataOf(idx), 1'b1);
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic applyStimulus(input logic r, input logic [3:0] q, input logic rdy);
    @(negedge clk);
    rstn      = r;
    req       = q;
    out_ready = rdy;
    #1;
  endtask

  task automatic checkOutput(input string nm, input logic [3:0] eg, input logic [1:0] es,
                             input logic care, input logic [3:0] eo, input logic ev);
    vectorsApplied++;
    if (grant !== eg) begin
      miscompares++;
      $display("[TB] FAIL %s grant: got %b want %b (t=%0t)", nm, grant, eg, $time);
    end
    if (care && (sel !== es)) begin
      miscompares++;
      $display("[TB] FAIL %s sel: got %0d want %0d (t=%0t)", nm, sel, es, $time);
    end
    if (out !== eo) begin
      miscompares++;
      $display("[TB] FAIL %s out: got %h want %h (t=%0t)", nm, out, eo, $time);
    end
    if (out_valid !== ev) begin
      miscompares++;
      $display("[TB] FAIL %s out_valid: got %b want %b (t=%0t)", nm, out_valid, ev, $time);
    end
  endtask

  initial begin
    rstn = 1'b0; req = 4'd0; out_ready = 1'b0;
    a = A_VAL; b = B_VAL; c = C_VAL; d = D_VAL;

    // Reset and idle.
    addVec("reset", 1'b0, 4'd0, 1'b0, 4'd0, 2'd0, 1'b1, 4'd0, 1'b0);
    for (int i = 0; i < 10; i++) addIdle("idle", 4'd0, 1'b1);

    // Round-robin fairness: a, b, c, d, a with a bubble between grants.
    addIdle("rr", 4'hF, 1'b1);
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < 4; j++) addBusy("rr", 4'hF, k % 4);
      addIdle("rr-gap", (k == 4) ? 4'h0 : 4'hF, 1'b0);
    end

    // Single requester c: re-granted every 4 beats after a 1-cycle bubble.
    addIdle("single", 4'h4, 1'b0);
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 4; j++) addBusy("single", 4'h4, 2);
      addIdle("single-gap", 4'h4, 1'b0);
    end
    addBusy("single", 4'h4, 2);
    addVec("single-drop", 1'b1, 4'h0, 1'b1, 4'b0100, 2'd2, 1'b1, 4'd0, 1'b0);
    addIdle("single-end", 4'h0, 1'b0);

    // Early withdrawal of a after 2 beats, then b after one bubble.
    addIdle("withdraw", 4'h3, 1'b0);
    addBusy("withdraw", 4'h3, 0);
    addBusy("withdraw", 4'h3, 0);
    addVec("drop-a", 1'b1, 4'h2, 1'b1, 4'b0001, 2'd0, 1'b1, 4'd0, 1'b0);
    addIdle("withdraw-gap", 4'h2, 1'b0);
    addBusy("withdraw-b", 4'h2, 1);
    addVec("drop-b", 1'b1, 4'h0, 1'b1, 4'b0010, 2'd1, 1'b1, 4'd0, 1'b0);
    addIdle("withdraw-end", 4'h0, 1'b0);

    foreach (vecTable[i]) begin
      applyStimulus(vecTable[i].rstn, vecTable[i].req, vecTable[i].rdy);
      checkOutput(vecTable[i].name, vecTable[i].grant, vecTable[i].sel,
                  vecTable[i].selCare, vecTable[i].out, vecTable[i].valid);
    end

    // Backpressure on b: 5 stalled cycles, then exactly 4 transfers and release.
    applyStimulus(1'b1, 4'h2, 1'b0);
    checkOutput("bp-idle", 4'd0, 2'd0, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 4'h2, 1'b0);
      checkOutput("bp-stall", 4'b0010, 2'd1, 1'b1, B_VAL, 1'b1);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 4'h2, 1'b1);
      checkOutput("bp-beat", 4'b0010, 2'd1, 1'b1, B_VAL, 1'b1);
    end
    applyStimulus(1'b1, 4'h0, 1'b1);
    checkOutput("bp-release", 4'd0, 2'd0, 1'b0, 4'd0, 1'b0);

    // Reset asserted during beat 2 of d's grant, then a wins first.
    applyStimulus(1'b1, 4'h8, 1'b1);
    checkOutput("rst-idle", 4'd0, 2'd0, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b1, 4'h8, 1'b1);
    checkOutput("rst-beat1", 4'b1000, 2'd3, 1'b1, D_VAL, 1'b1);
    applyStimulus(1'b1, 4'h8, 1'b1);
    checkOutput("rst-beat2", 4'b1000, 2'd3, 1'b1, D_VAL, 1'b1);
    #1 rstn = 1'b0;
    #1;
    checkOutput("rst-async", 4'd0, 2'd0, 1'b1, 4'd0, 1'b0);
    applyStimulus(1'b0, 4'h9, 1'b1);
    checkOutput("rst-held", 4'd0, 2'd0, 1'b1, 4'd0, 1'b0);
    applyStimulus(1'b1, 4'h9, 1'b1);
    checkOutput("rst-released", 4'd0, 2'd0, 1'b1, 4'd0, 1'b0);
    applyStimulus(1'b1, 4'h9, 1'b1);
    checkOutput("rst-a-first", 4'b0001, 2'd0, 1'b1, A_VAL, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
